// File: rtl/uart_top.sv
// Full-duplex 8N1 UART: an oversampling receiver and a transmitter with a one-byte
// holding register, both clocked by i_clk and otherwise independent.
module uart_top #(
   parameter int CLK_FREQ     = 125_000_000,
   parameter int BAUD         = 115_200,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_srx,
   output logic [7:0] o_Rx_data,
   output logic       o_Rx_valid,
   input  logic       i_Tx_valid,
   input  logic [7:0] i_Tx_data,
   output logic       o_stx
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } uartState_t;

   logic             r_srxMeta;
   logic             r_srxSync;
   uartState_t       r_rxState;
   logic [CNT_W-1:0] r_rxCnt;
   logic [2:0]       r_rxBitIdx;
   logic [7:0]       r_rxShift;
   logic             r_rxBreak;

   uartState_t       r_txState;
   logic [CNT_W-1:0] r_txCnt;
   logic [2:0]       r_txBitIdx;
   logic [7:0]       r_txShift;
   logic [7:0]       r_holdData;
   logic             r_holdFull;
   logic             r_txValidPrev;
   logic             w_txAccept;

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_srxMeta <= 1'b1;
         r_srxSync <= 1'b1;
      end else begin
         r_srxMeta <= i_srx;
         r_srxSync <= r_srxMeta;
      end
   end

   // Receiver: half-bit start qualification, then one sample per bit centre.
   // A framing error sets r_rxBreak so the line must return high before re-arming.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rxState  <= S_IDLE;
         r_rxCnt    <= '0;
         r_rxBitIdx <= '0;
         r_rxShift  <= '0;
         r_rxBreak  <= 1'b0;
         o_Rx_data  <= '0;
         o_Rx_valid <= 1'b0;
      end else begin
         o_Rx_valid <= 1'b0;
         case (r_rxState)
            S_IDLE: begin
               r_rxCnt <= '0;
               if (r_srxSync) begin
                  r_rxBreak <= 1'b0;
               end else if (!r_rxBreak) begin
                  r_rxState <= S_START;
               end
            end
            S_START: begin
               if (r_rxCnt == HALF_LAST) begin
                  r_rxCnt    <= '0;
                  r_rxBitIdx <= '0;
                  r_rxState  <= r_srxSync ? S_IDLE : S_DATA;
               end else begin
                  r_rxCnt <= r_rxCnt + CNT_ONE;
               end
            end
            S_DATA: begin
               if (r_rxCnt == BIT_LAST) begin
                  r_rxCnt   <= '0;
                  r_rxShift <= {r_srxSync, r_rxShift[7:1]};
                  if (r_rxBitIdx == 3'd7) begin
                     r_rxState <= S_STOP;
                  end else begin
                     r_rxBitIdx <= r_rxBitIdx + 3'd1;
                  end
               end else begin
                  r_rxCnt <= r_rxCnt + CNT_ONE;
               end
            end
            S_STOP: begin
               if (r_rxCnt == BIT_LAST) begin
                  r_rxCnt   <= '0;
                  r_rxState <= S_IDLE;
                  if (r_srxSync) begin
                     o_Rx_data  <= r_rxShift;
                     o_Rx_valid <= 1'b1;
                  end else begin
                     r_rxBreak <= 1'b1;
                  end
               end else begin
                  r_rxCnt <= r_rxCnt + CNT_ONE;
               end
            end
            default: r_rxState <= S_IDLE;
         endcase
      end
   end

   assign w_txAccept = i_Tx_valid & ~r_txValidPrev;

   // Transmitter with holding register. STOP chains straight into START when a
   // byte is waiting so the stop bit is exactly one bit period long.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_txState     <= S_IDLE;
         r_txCnt       <= '0;
         r_txBitIdx    <= '0;
         r_txShift     <= '0;
         r_holdData    <= '0;
         r_holdFull    <= 1'b0;
         r_txValidPrev <= 1'b0;
         o_stx         <= 1'b1;
      end else begin
         r_txValidPrev <= i_Tx_valid;
         if (w_txAccept && !r_holdFull) begin
            r_holdData <= i_Tx_data;
            r_holdFull <= 1'b1;
         end
         case (r_txState)
            S_IDLE: begin
               r_txCnt <= '0;
               o_stx   <= 1'b1;
               if (r_holdFull) begin
                  r_txShift  <= r_holdData;
                  r_holdFull <= 1'b0;
                  o_stx      <= 1'b0;
                  r_txState  <= S_START;
               end
            end
            S_START: begin
               if (r_txCnt == BIT_LAST) begin
                  r_txCnt    <= '0;
                  r_txBitIdx <= '0;
                  o_stx      <= r_txShift[0];
                  r_txState  <= S_DATA;
               end else begin
                  r_txCnt <= r_txCnt + CNT_ONE;
               end
            end
            S_DATA: begin
               if (r_txCnt == BIT_LAST) begin
                  r_txCnt <= '0;
                  if (r_txBitIdx == 3'd7) begin
                     o_stx     <= 1'b1;
                     r_txState <= S_STOP;
                  end else begin
                     r_txBitIdx <= r_txBitIdx + 3'd1;
                     r_txShift  <= {1'b0, r_txShift[7:1]};
                     o_stx      <= r_txShift[1];
                  end
               end else begin
                  r_txCnt <= r_txCnt + CNT_ONE;
               end
            end
            S_STOP: begin
               if (r_txCnt == BIT_LAST) begin
                  r_txCnt <= '0;
                  if (r_holdFull) begin
                     r_txShift  <= r_holdData;
                     r_holdFull <= 1'b0;
                     o_stx      <= 1'b0;
                     r_txState  <= S_START;
                  end else begin
                     r_txState <= S_IDLE;
                  end
               end else begin
                  r_txCnt <= r_txCnt + CNT_ONE;
               end
            end
            default: r_txState <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_top.sv
// Scoreboarded bench for uart_top: stimulus pushes expected bytes and TX start cycles,
// independent monitors decode o_Rx_valid pulses and o_stx frames and compare.
module tb_uart_top;

   localparam int CLK_FREQ = 800_000;
   localparam int BAUD     = 100_000;
   localparam int CPB      = CLK_FREQ / BAUD;

   logic       clk = 1'b0;
   logic       i_rst;
   logic       i_srx;
   logic [7:0] o_Rx_data;
   logic       o_Rx_valid;
   logic       i_Tx_valid;
   logic [7:0] i_Tx_data;
   logic       o_stx;

   typedef struct {
      logic [7:0] data;
      int         start;
   } txExp_t;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   bit         monEnable = 1'b0;
   logic [7:0] rxExpQ[$];
   txExp_t     txExpQ[$];
   int         lastPredStart = -100000;
   int         rxStartCyc = 0;
   int         lastRxCyc = 0;
   int         rxPulses = 0;
   int         txFrames = 0;
   logic       prevValid = 1'b0;

   uart_top #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD(BAUD)
   ) dut (
      .i_clk(clk),
      .i_rst(i_rst),
      .i_srx(i_srx),
      .o_Rx_data(o_Rx_data),
      .o_Rx_valid(o_Rx_valid),
      .i_Tx_valid(i_Tx_valid),
      .i_Tx_data(i_Tx_data),
      .o_stx(o_stx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   // Drives one frame starting at the current negedge; returns at the negedge ending the stop bit.
   task automatic sendRxFrame(input logic [7:0] d, input logic stopBit, input bit expectIt);
      i_srx = 1'b0;
      rxStartCyc = cyc;
      if (expectIt) rxExpQ.push_back(d);
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         i_srx = d[i];
         repeat (CPB) @(negedge clk);
      end
      i_srx = stopBit;
      repeat (CPB) @(negedge clk);
   endtask

   // Rising edge on i_Tx_valid held for len cycles. The model accepts it only when the
   // previously accepted byte has already left the holding register, and predicts its
   // start bit either 2 cycles after accept or right after the previous frame's stop bit.
   task automatic applyStimulus(input logic [7:0] d, input int len);
      int r;
      int pred;
      @(negedge clk);
      i_Tx_data  = d;
      i_Tx_valid = 1'b1;
      r = cyc;
      if (r >= lastPredStart) begin
         pred = (r + 2 > lastPredStart + 10 * CPB) ? r + 2 : lastPredStart + 10 * CPB;
         txExpQ.push_back('{data: d, start: pred});
         lastPredStart = pred;
      end
      repeat (len) @(negedge clk);
      i_Tx_valid = 1'b0;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (monEnable) begin
         if (o_Rx_valid) begin
            rxPulses++;
            lastRxCyc = cyc;
            checkOutput("rx_pulse_width", {31'd0, prevValid}, 32'd0);
            if (rxExpQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL rx_unexpected_byte actual=0x%0h required=no pulse", o_Rx_data);
            end else begin
               checkOutput("rx_data", {24'd0, o_Rx_data}, {24'd0, rxExpQ.pop_front()});
            end
         end
         prevValid = o_Rx_valid;
      end
   end

   initial begin : txMonitor
      int         f;
      logic [7:0] b;
      logic       stopBit;
      txExp_t     e;
      wait (monEnable);
      forever begin
         @(negedge clk);
         if (o_stx === 1'b0) begin
            f = cyc;
            repeat (CPB + CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               b[i] = o_stx;
               if (i < 7) repeat (CPB) @(negedge clk);
            end
            repeat (CPB) @(negedge clk);
            stopBit = o_stx;
            txFrames++;
            checkOutput("tx_stop_bit", {31'd0, stopBit}, 32'd1);
            if (txExpQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL tx_unexpected_frame actual=0x%0h required=no frame", b);
            end else begin
               e = txExpQ.pop_front();
               checkOutput("tx_data", {24'd0, b}, {24'd0, e.data});
               checkOutput("tx_start_cycle", f, e.start);
            end
         end
      end
   end

   initial begin
      int baseLat;
      int lat;
      int p;
      int target;
      i_rst      = 1'b1;
      i_srx      = 1'b1;
      i_Tx_valid = 1'b0;
      i_Tx_data  = 8'h00;
      repeat (2) @(negedge clk);
      i_rst = 1'b0;
      checkOutput("reset_stx", {31'd0, o_stx}, 32'd1);
      checkOutput("reset_rx_valid", {31'd0, o_Rx_valid}, 32'd0);
      checkOutput("reset_rx_data", {24'd0, o_Rx_data}, 32'd0);
      monEnable = 1'b1;

      $display("[TB] sweeps: RX 0x00..0xFF back-to-back, TX 0x00..0xFF queued");
      fork
         for (int b = 0; b < 256; b++) sendRxFrame(8'(b), 1'b1, 1'b1);
         for (int b = 0; b < 256; b++) begin
            target = lastPredStart + int'($urandom_range(0, 9 * CPB));
            while (cyc < target - 1) @(negedge clk);
            applyStimulus(8'(b), 2);
         end
      join
      repeat (12 * CPB) @(negedge clk);
      checkOutput("rx_sweep_pulses", rxPulses, 256);
      checkOutput("rx_sweep_queue_left", rxExpQ.size(), 0);
      checkOutput("tx_sweep_frames", txFrames, 256);

      $display("[TB] rx errors: glitch and framing error");
      i_srx = 1'b0;
      repeat (2) @(negedge clk);
      i_srx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      sendRxFrame(8'hA5, 1'b0, 1'b0);
      i_srx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      checkOutput("rx_error_no_pulse", rxPulses, 256);
      checkOutput("rx_data_held", {24'd0, o_Rx_data}, 32'hFF);
      sendRxFrame(8'h3C, 1'b1, 1'b1);
      repeat (2 * CPB) @(negedge clk);
      checkOutput("rx_after_error_pulses", rxPulses, 257);
      baseLat = lastRxCyc - rxStartCyc;
      checkOutput("rx_latency_window", {31'd0, (baseLat >= 19 * CPB / 2) && (baseLat <= 10 * CPB + 4)}, 32'd1);

      $display("[TB] tx queueing and drop");
      applyStimulus(8'h55, 2);
      p = lastPredStart;
      target = p + 9 * CPB + CPB / 2 - 2;
      while (cyc < target - 1) @(negedge clk);
      applyStimulus(8'hC3, 1);
      applyStimulus(8'h99, 1);
      while (cyc < p + 32 * CPB) @(negedge clk);
      checkOutput("tx_queue_frames", txFrames, 258);
      checkOutput("tx_queue_left", txExpQ.size(), 0);

      $display("[TB] concurrency: RX 0x81 with TX 0x7E");
      fork
         sendRxFrame(8'h81, 1'b1, 1'b1);
         applyStimulus(8'h7E, 2);
      join
      repeat (12 * CPB) @(negedge clk);
      lat = lastRxCyc - rxStartCyc;
      checkOutput("rx_latency_under_tx", lat, baseLat);
      checkOutput("concurrent_rx_pulses", rxPulses, 258);
      checkOutput("concurrent_tx_frames", txFrames, 259);

      $display("[TB] random traffic");
      fork
         for (int k = 0; k < 20; k++) begin
            sendRxFrame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
            i_srx = 1'b1;
            repeat ($urandom_range(0, 2 * CPB)) @(negedge clk);
         end
         for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(1, 6 * CPB)) @(negedge clk);
            applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
         end
      join
      repeat (25 * CPB) @(negedge clk);
      checkOutput("random_rx_queue_left", rxExpQ.size(), 0);
      checkOutput("random_tx_queue_left", txExpQ.size(), 0);
      checkOutput("random_rx_pulses", rxPulses, 278);

      $display("[TB] reset during an RX frame");
      i_srx = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      i_rst = 1'b1;
      i_srx = 1'b1;
      repeat (2) @(negedge clk);
      i_rst = 1'b0;
      checkOutput("midreset_rx_data", {24'd0, o_Rx_data}, 32'd0);
      checkOutput("midreset_stx", {31'd0, o_stx}, 32'd1);
      repeat (12 * CPB) @(negedge clk);
      checkOutput("midreset_no_pulse", rxPulses, 278);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
